// File: rtl/trigger_pkg.sv
// Shared types and default parameter values for the trigger conditioning path.
//   trig_state_e        : debounce FSM state encoding
//   *_DEF               : default parameter values for trigger_conditioner
package trigger_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    PEND_HIGH = 2'd1,
    HIGH      = 2'd2,
    PEND_LOW  = 2'd3
  } trig_state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_WIDTH_DEF       = 8;

endpackage

// File: rtl/trigger_conditioner_sync.sv
// bit_synchronizer: multi-flop synchroniser for one asynchronous input bit.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronised output (last stage of the chain)
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/trigger_conditioner.sv
// trigger_conditioner: synchronises and debounces a raw trigger level, emits
// one-cycle rise/fall pulses and counts accepted rising triggers.
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset (highest priority)
//   in         : raw asynchronous trigger level
//   count_clr  : synchronous clear of trig_count and overflow
//   level_out  : debounced level (1 in HIGH and PEND_LOW)
//   rise_pulse : one cycle on entry to HIGH from LOW/PEND_HIGH
//   fall_pulse : one cycle on entry to LOW from HIGH/PEND_LOW
//   trig_count : accepted rising triggers, modulo 2^CNT_WIDTH
//   overflow   : sticky, set when trig_count wraps
module trigger_conditioner
  import trigger_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  input  logic                 count_clr,
  output logic                 level_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] trig_count,
  output logic                 overflow
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES);

  logic s;

  trig_state_e          state_q, state_d;
  logic [DCW-1:0]       deb_q, deb_d, deb_inc;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (in),
    .q  (s)
  );

  assign deb_inc = deb_q + DCW'(1);

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    case (state_q)
      LOW: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HIGH;
            deb_d   = '0;
          end else begin
            state_d = PEND_HIGH;
            deb_d   = DCW'(1);
          end
        end
      end
      PEND_HIGH: begin
        if (!s) begin
          state_d = LOW;
          deb_d   = '0;
        end else if (deb_inc == DEB_LAST) begin
          state_d = HIGH;
          deb_d   = '0;
        end else begin
          deb_d = deb_inc;
        end
      end
      HIGH: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = LOW;
            deb_d   = '0;
          end else begin
            state_d = PEND_LOW;
            deb_d   = DCW'(1);
          end
        end
      end
      PEND_LOW: begin
        if (s) begin
          state_d = HIGH;
          deb_d   = '0;
        end else if (deb_inc == DEB_LAST) begin
          state_d = LOW;
          deb_d   = '0;
        end else begin
          deb_d = deb_inc;
        end
      end
      default: begin
        state_d = LOW;
        deb_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same
  // edge the FSM changes; returning from a pending state gives no pulse.
  always_comb begin
    level_d = (state_d == HIGH) || (state_d == PEND_LOW);
    rise_d  = (state_d == HIGH) && ((state_q == LOW) || (state_q == PEND_HIGH));
    fall_d  = (state_d == LOW)  && ((state_q == HIGH) || (state_q == PEND_LOW));
  end

  // Clear is applied first so a clear coinciding with a rise yields a count of 1.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (count_clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
    if (rise_d) begin
      if (cnt_d == '1) begin
        ovf_d = 1'b1;
      end
      cnt_d = cnt_d + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      deb_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign trig_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Bench for trigger_conditioner: a default instance and a CNT_WIDTH=2 instance
// share stimulus; expected pulse events are queued when stimulus is driven and
// popped when either instance pulses.
module tb_trigger_conditioner;
  import trigger_pkg::*;

  // Input driven after edge d is first seen at edge d+1; output visible after
  // edge d+1+SYNC+DEB-1.
  localparam int LAT = SYNC_STAGES_DEF + DEBOUNCE_CYCLES_DEF;

  logic       clk = 1'b0;
  logic       rst, trig_in, count_clr;
  logic       level_a, rise_a, fall_a, ovf_a;
  logic [7:0] cnt_a;
  logic       level_b, rise_b, fall_b, ovf_b;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  trigger_conditioner u_dut_a (
    .clk(clk), .rst(rst), .in(trig_in), .count_clr(count_clr),
    .level_out(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .trig_count(cnt_a), .overflow(ovf_a)
  );

  trigger_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .in(trig_in), .count_clr(count_clr),
    .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .trig_count(cnt_b), .overflow(ovf_b)
  );

  typedef struct {
    bit         is_rise;
    int         cyc;
    logic [7:0] cnt_a;
    logic       ovf_a;
    logic [1:0] cnt_b;
    logic       ovf_b;
  } ev_t;

  typedef struct {
    string name;
    int    hi_len;
    int    lo_len;
    bit    clr_at_rise;
    bit    exp_rise;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_cnt_a = 0, m_cnt_b = 0;
  bit   m_ovf_a = 0, m_ovf_b = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic push_ev(input bit is_rise, input int at, input bit clr);
    ev_t e;
    if (is_rise) begin
      if (clr) begin
        m_cnt_a = 0; m_ovf_a = 0; m_cnt_b = 0; m_ovf_b = 0;
      end
      if (m_cnt_a == 255) m_ovf_a = 1;
      m_cnt_a = (m_cnt_a + 1) % 256;
      if (m_cnt_b == 3) m_ovf_b = 1;
      m_cnt_b = (m_cnt_b + 1) % 4;
    end
    e.is_rise = is_rise;
    e.cyc     = at;
    e.cnt_a   = 8'(m_cnt_a);
    e.ovf_a   = m_ovf_a;
    e.cnt_b   = 2'(m_cnt_b);
    e.ovf_b   = m_ovf_b;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    ev_t e;
    if (rise_a || fall_a || rise_b || fall_b) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got rise/fall a=%b%b b=%b%b exp none",
                 cyc, rise_a, fall_a, rise_b, fall_b);
      end else begin
        e = exp_q.pop_front();
        check("pulse_time", 64'(cyc), 64'(e.cyc));
        check("pulse_kind", {60'd0, rise_a, fall_a, rise_b, fall_b},
              e.is_rise ? 64'b1010 : 64'b0101);
        check("level", {62'd0, level_a, level_b}, {62'd0, e.is_rise, e.is_rise});
        check("cnt_a", {56'd0, cnt_a}, {56'd0, e.cnt_a});
        check("ovf_a", {63'd0, ovf_a}, {63'd0, e.ovf_a});
        check("cnt_b", {62'd0, cnt_b}, {62'd0, e.cnt_b});
        check("ovf_b", {63'd0, ovf_b}, {63'd0, e.ovf_b});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic check_quiet(input string name);
    check(name, {52'd0, level_a, rise_a, fall_a, ovf_a, cnt_a},
          {52'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    check({name, "_b"}, {58'd0, level_b, rise_b, fall_b, ovf_b, cnt_b}, 64'd0);
  endtask

  initial begin
    int d, f;
    vecs[0] = '{name: "glitch3",  hi_len: 3,  lo_len: 10, clr_at_rise: 0, exp_rise: 0};
    vecs[1] = '{name: "edge4",    hi_len: 4,  lo_len: 10, clr_at_rise: 0, exp_rise: 1};
    vecs[2] = '{name: "glitch1",  hi_len: 1,  lo_len: 10, clr_at_rise: 0, exp_rise: 0};
    vecs[3] = '{name: "hold8",    hi_len: 8,  lo_len: 10, clr_at_rise: 0, exp_rise: 1};
    vecs[4] = '{name: "hold20",   hi_len: 20, lo_len: 10, clr_at_rise: 0, exp_rise: 1};
    vecs[5] = '{name: "hold5",    hi_len: 5,  lo_len: 10, clr_at_rise: 0, exp_rise: 1};
    vecs[6] = '{name: "hold6",    hi_len: 6,  lo_len: 10, clr_at_rise: 0, exp_rise: 1};
    vecs[7] = '{name: "clr_rise", hi_len: 10, lo_len: 10, clr_at_rise: 1, exp_rise: 1};

    rst = 1'b1; trig_in = 1'b0; count_clr = 1'b0;
    repeat (3) tick();
    check_quiet("reset_state");
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      check_quiet("idle");
    end

    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        // standalone clear after the narrow counter has wrapped
        check("ovf_b_before_clr", {63'd0, ovf_b}, 64'd1);
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 0; m_ovf_b = 0;
        check_quiet("count_clr");
      end
      d = cyc;
      trig_in = 1'b1;
      if (vecs[i].exp_rise) push_ev(1'b1, d + LAT, vecs[i].clr_at_rise);
      for (int k = 0; k < vecs[i].hi_len; k++) begin
        if (vecs[i].clr_at_rise) count_clr = (cyc == d + LAT - 1);
        tick();
      end
      count_clr = 1'b0;
      trig_in = 1'b0;
      f = cyc;
      if (vecs[i].exp_rise) push_ev(1'b0, f + LAT, 1'b0);
      repeat (vecs[i].lo_len) tick();
      check({"missing_event_", vecs[i].name}, 64'(exp_q.size()), 64'd0);
      check({"level_low_", vecs[i].name}, {62'd0, level_a, level_b}, 64'd0);
    end

    // Reset two cycles into PEND_HIGH with the input held high.
    d = cyc;
    trig_in = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_quiet("mid_pend_reset");
    rst = 1'b0;
    m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 0; m_ovf_b = 0;
    push_ev(1'b1, d + 6 + LAT - 1, 1'b0);
    while (cyc < d + 20) begin
      tick();
      if (cyc < d + 6 + LAT - 1) check("level_during_requal", {63'd0, level_a}, 64'd0);
    end
    trig_in = 1'b0;
    f = cyc;
    push_ev(1'b0, f + LAT, 1'b0);
    repeat (12) tick();
    check("missing_event_reset", 64'(exp_q.size()), 64'd0);
    check("final_cnt_a", {56'd0, cnt_a}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_conditioner.md
Name: trigger_conditioner

Overview:
- Downstream consumer of the single-bit trigger wire: synchronises the raw trigger, debounces it, emits one-cycle rise/fall pulses and counts accepted triggers.
- Sits between the raw pass-through wire stage and any control logic that needs clean, counted trigger events.

Parameters:
- SYNC_STAGES, 2, synchroniser depth in flops; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples required to accept a level change; must be >= 1.
- CNT_WIDTH, 8, width of the trigger event counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  raw trigger level, asynchronous to clk.
- count_clr  input  1  synchronous clear of trig_count and overflow.
- level_out  output  1  debounced trigger level.
- rise_pulse  output  1  one-cycle pulse when level_out goes 0->1.
- fall_pulse  output  1  one-cycle pulse when level_out goes 1->0.
- trig_count  output  CNT_WIDTH  number of accepted rising triggers, modulo 2^CNT_WIDTH.
- overflow  output  1  sticky flag, set when trig_count wraps.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All synchroniser flops go to 0 and the FSM goes to LOW.
  - The debounce counter, level_out, rise_pulse, fall_pulse, trig_count and overflow all go to 0.
  - rst has priority over every other input.
- Synchroniser: an SYNC_STAGES-deep flop chain; its last stage is "s".
- FSM states: LOW, PEND_HIGH, HIGH, PEND_LOW. A debounce counter of width $clog2(DEBOUNCE_CYCLES+1) tracks consecutive differing samples.
  - LOW: if s=1, load counter=1. If DEBOUNCE_CYCLES=1, go directly to HIGH; otherwise go to PEND_HIGH.
  - PEND_HIGH:
    - If s=0, return to LOW and clear the counter (glitch rejected; no pulse).
    - If s=1, increment the counter. When it reaches DEBOUNCE_CYCLES, go to HIGH.
  - HIGH and PEND_LOW mirror LOW and PEND_HIGH with the polarity inverted.
- Outputs are registered:
  - level_out is 1 exactly in HIGH and PEND_LOW.
  - rise_pulse is 1 for exactly one cycle, on the edge that enters HIGH from LOW or PEND_HIGH. fall_pulse is the same for entry to LOW from HIGH or PEND_LOW.
- Latency: if in changes before edge E0 and stays stable, level_out and the pulse become visible after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1. With default parameters this is E0+5.
- Input bursts: any excursion of s shorter than DEBOUNCE_CYCLES produces no output change. Pulses never occur back to back faster than DEBOUNCE_CYCLES cycles apart.
- trig_count:
  - Increments by 1 on every rise_pulse and wraps from 2^CNT_WIDTH-1 to 0. On that wrap, overflow is set and stays set until count_clr or rst.
  - count_clr on the same edge as a rise: trig_count=1, overflow=0 (clear first, then increment).
  - count_clr alone: trig_count=0, overflow=0. count_clr does not affect the FSM or level_out.
- Reset asserted mid-pending: all pending state is discarded. After rst deasserts, a held-high input re-qualifies from scratch with the full latency, and rise_pulse fires at the normal time.

Decomposition:
- Package trigger_pkg holds:
  - the state typedef enum {LOW, PEND_HIGH, HIGH, PEND_LOW} (2 bits);
  - default constants SYNC_STAGES_DEF=2, DEBOUNCE_CYCLES_DEF=4, CNT_WIDTH_DEF=8.
- One sub-module: bit_synchronizer (parameter STAGES; ports clk, rst, d, q). It is reused for any other asynchronous single-bit input.
- The FSM, debounce counter and event counter stay in trigger_conditioner.

Test Plan:
- Reset, then in=0 for 20 cycles -> level_out=0, no pulses, trig_count=0, overflow=0.
- in 0->1 before edge E0, held high -> rise_pulse=1 only in the cycle after edge E0+5; level_out=1 from then on; trig_count=1.
- Glitch: in=1 for 3 cycles then 0 (defaults) -> no rise_pulse; level_out stays 0; trig_count stays 0.
- With CNT_WIDTH=2, five clean triggers -> trig_count sequence 1,2,3,0,1; overflow=1 from the 4th trigger onward; then count_clr -> trig_count=0, overflow=0.
- count_clr asserted on the same edge as rise_pulse -> trig_count=1, overflow=0.
- rst asserted 2 cycles into PEND_HIGH with in held high, deasserted 1 cycle later -> level_out=0 through reset; rise_pulse occurs SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after the first post-reset edge; trig_count=1.
